// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: reduction FSM states and iteration-count helpers.
package rsa_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } red_state_e;

  // One shift/subtract iteration per dividend bit.
  function automatic int unsigned iter_count(input int unsigned width);
    return 2 * width;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/mod_sub_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// then subtract the modulus if the shifted value is not below it.
module mod_sub_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] mod_i,
  output logic [WIDTH-1:0] r_o
);

  logic [WIDTH:0] shifted;
  logic           ge;

  always_comb begin
    shifted = {r_i, bit_i};
    ge      = shifted >= {1'b0, mod_i};
    // The low WIDTH bits of the difference are exact; the top bit of r' is
    // always 0 when mod != 0 and is dropped by the next shift when mod == 0.
    r_o     = ge ? (shifted[WIDTH-1:0] - mod_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_reduce.sv
// Sequential in mod N reduction, one dividend bit per cycle, constant latency by default.
// Optional MOD_REDUCE_FAST_PATH_EN: finish after one cycle when in < mod (data-dependent).
module mod_reduce
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] in,
  input  logic [WIDTH-1:0]   mod,
  output logic [WIDTH-1:0]   out,
  output logic               finish
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] IterCnt = CntW'(iter_count(WIDTH));

  red_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0]   mod_q, mod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               finish_q, finish_d;
  logic [WIDTH-1:0]   step_r;

  mod_sub_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_i  (rem_q),
    .bit_i(dividend_q[2*WIDTH-1]),
    .mod_i(mod_q),
    .r_o  (step_r)
  );

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    mod_d      = mod_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    finish_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dividend_d = in;
          mod_d      = mod;
          rem_d      = '0;
          cnt_d      = IterCnt;
          state_d    = StRun;
`ifdef MOD_REDUCE_FAST_PATH_EN
          if (in < {{WIDTH{1'b0}}, mod}) begin
            rem_d   = in[WIDTH-1:0];
            cnt_d   = '0;
            state_d = StDone;
          end
`endif
        end
      end
      StRun: begin
        dividend_d = dividend_q << 1;
        rem_d      = step_r;
        cnt_d      = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_d    = rem_q;
        finish_d = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      mod_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      mod_q      <= mod_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      finish_q   <= finish_d;
    end
  end

  assign out    = out_q;
  assign finish = finish_q;

endmodule

// File: tb/tb_mod_reduce.sv
// Scoreboard bench for mod_reduce: results, exact latency, pulse width, reset abort.
module tb_mod_reduce;

  localparam int unsigned W = 8;
  localparam int Bound = 100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*W-1:0] in_v = '0;
  logic [W-1:0]   mod_v = '0;
  logic [W-1:0]   out;
  logic           finish;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mod_reduce #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in_v),
    .mod   (mod_v),
    .out   (out),
    .finish(finish)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_res(input logic [2*W-1:0] a, input logic [W-1:0] m);
    logic [2*W-1:0] r;
    if (m == '0) return a[W-1:0];
    r = a % {{W{1'b0}}, m};
    return r[W-1:0];
  endfunction

  function automatic int ref_lat(input logic [2*W-1:0] a, input logic [W-1:0] m);
`ifdef MOD_REDUCE_FAST_PATH_EN
    if (a < {{W{1'b0}}, m}) return 1;
`endif
    return 2 * W + 1;
  endfunction

  // Drives one start across a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] m);
    exp_t e;
    e.res = ref_res(a, m);
    e.lat = ref_lat(a, m);
    sb.push_back(e);
    in_v  = a;
    mod_v = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_finish(output int lat);
    lat = 0;
    while (finish !== 1'b1 && lat < Bound) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out !== '0) begin
      errors++; $display("FAIL reset_out got %0h want 0", out);
    end
    checks++;
    if (finish !== 1'b0) begin
      errors++; $display("FAIL reset_finish got %0b want 0", finish);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_op(input string name, input logic [2*W-1:0] a, input logic [W-1:0] m);
    int   lat;
    exp_t e;
    @(negedge clk);
    issue(a, m);
    wait_finish(lat);
    e = sb.pop_front();
    checks++;
    if (out !== e.res) begin
      errors++; $display("FAIL %s_out got %0h want %0h", name, out, e.res);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, e.lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if (finish !== 1'b0) begin
      errors++; $display("FAIL %s_pulse_width got finish=%0b want 0", name, finish);
    end
  endtask

  task automatic test_ignore_during_run;
    int           lat;
    int           extra;
    logic [W-1:0] held;
    exp_t         e;
    @(negedge clk);
    issue(16'h1234, 8'd143);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_v  = 16'hFFFF;
    mod_v = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish(lat);
    e = sb.pop_front();
    checks++;
    if (out !== e.res) begin
      errors++; $display("FAIL ignore_out got %0h want %0h", out, e.res);
    end
    held  = out;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) extra++;
      if (out !== held) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL ignore_single_finish got %0d extra events want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run;
    int   seen;
    exp_t e;
    @(negedge clk);
    issue(16'h1234, 8'd143);
    e = sb.pop_front();  // aborted, never completes
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== '0) begin
      errors++; $display("FAIL midreset_out got %0h want 0", out);
    end
    checks++;
    if (finish !== 1'b0) begin
      errors++; $display("FAIL midreset_finish got %0b want 0", finish);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (finish === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midreset_no_finish got %0d pulses want 0 (res %0h)", seen, e.res);
    end
    test_op("after_reset", 16'h1234, 8'd143);
  endtask

  task automatic test_back_to_back;
    int             lat;
    exp_t           e;
    logic [2*W-1:0] a;
    logic [W-1:0]   m;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      m = W'($urandom_range(0, 255));
      if (i % 6 == 5) m = '0;
      a = (i % 4 == 3) ? (2*W)'($urandom_range(0, 300)) : (2*W)'($urandom);
      issue(a, m);
      if (i > 0) begin
        checks++;
        if (finish !== 1'b0) begin
          errors++; $display("FAIL b2b_pulse_width[%0d] got finish=%0b want 0", i, finish);
        end
      end
      wait_finish(lat);
      e = sb.pop_front();
      checks++;
      if (out !== e.res) begin
        errors++;
        $display("FAIL b2b_out[%0d] in=%0h mod=%0h got %0h want %0h", i, a, m, out, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, e.lat);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (finish !== 1'b0) begin
      errors++; $display("FAIL b2b_last_pulse got finish=%0b want 0", finish);
    end
  endtask

  initial begin
    test_reset();
    test_op("basic", 16'h1234, 8'd143);
    test_op("all_ones", 16'hFFFF, 8'hFF);
    test_op("below_mod", 16'h00FE, 8'hFF);
    test_op("mod_one", 16'hABCD, 8'd1);
    test_op("mod_zero", 16'h1234, 8'd0);
    test_ignore_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_reduce.md
# mod_reduce

Sequential modular-reduction stage that consumes the 2*WIDTH-bit product of the shift-add multiplier and returns product mod N as a WIDTH-bit residue. It sits directly downstream of the multiplier in the RSA datapath; the modular-exponentiation loop runs multiply then reduce once per step. It uses the same start/finish handshake as the multiplier. Its latency is a timing-side-channel concern, so the block's timing is specified exactly.

## Interface
- WIDTH, 8, operand/modulus width; product input is 2*WIDTH bits
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- in  input  2*WIDTH  dividend (multiplier product), captured on accepted start
- mod  input  WIDTH  modulus N, captured on accepted start
- out  output  WIDTH  residue, registered, held until the next completion
- finish  output  1  one-cycle pulse; out is valid in the same cycle

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start: capture in and mod. Load the remainder register (WIDTH+1 bits) with 0 and the bit counter with 2*WIDTH. Go to RUN. Fast-path exception below.
- RUN, one dividend bit per cycle, MSB first:
  - r' = {r[WIDTH-1:0], next bit}
  - if r' >= {1'b0, mod}, r' = r' - mod
  - decrement the counter; when it reaches 0, go to DONE.
- DONE: out <= r[WIDTH-1:0], finish = 1 for this cycle only, return to IDLE.
- start is ignored in RUN and DONE. No queuing; a request is lost if start is not re-asserted in IDLE.
- mod == 0: the datapath naturally yields in[WIDTH-1:0]. This is the defined result, with normal latency.
- Captured operands are immune to input changes after acceptance.
- Reset (asynchronous, at any time, including mid-RUN): state = IDLE, out = 0, finish = 0, remainder = 0, counter = 0. The aborted operation produces no finish.

## Timing
- Start accepted at edge k.
- RUN occupies cycles k+1 .. k+2*WIDTH.
- finish is high for the single cycle after edge k+2*WIDTH+1. Latency is 2*WIDTH+1 cycles (17 for WIDTH=8).
- Earliest next accepted start is the edge after finish: back-to-back throughput is one result per 2*WIDTH+2 cycles.
- Fast path, when enabled: finish is high the cycle after edge k+1 (latency 1).
- out changes only on the DONE transition. Between results it holds the previous value (0 after reset).

## Configuration
- Macro: MOD_REDUCE_FAST_PATH_EN.
- Defined: in IDLE + start with in < {WIDTH'b0, mod}, go straight to DONE with out = in[WIDTH-1:0], skipping RUN. Latency is 1, which is data-dependent (a deliberate leaky variant used in side-channel experiments).
- Undefined (default): no comparison at start. Every operation, including in < mod and mod == 0, takes exactly 2*WIDTH+1 cycles (constant time).

## Structure
- Shared package rsa_pkg holds:
  - the FSM state typedef (IDLE/RUN/DONE)
  - a localparam/function for the iteration count (2*WIDTH)
  - its counter width, $clog2(2*WIDTH+1)
- One natural sub-module: mod_sub_step. It is the combinational shift-in/compare/conditional-subtract step.
  - Inputs: r, bit, mod. Output: r'.
  - Instantiated once; the top holds the FSM and registers.

## Test plan
- WIDTH=8, in=0x1234, mod=143 -> out=84 (0x54), finish exactly 17 cycles after start, single-cycle pulse.
- in=0xFFFF, mod=0xFF -> out=0. Then in=0x00FE, mod=0xFF -> out=0xFE. Check latency: 17 without the macro, 1 with MOD_REDUCE_FAST_PATH_EN.
- mod=1, in=0xABCD -> out=0. mod=0, in=0x1234 -> out=0x34, latency 17.
- start re-pulsed and in/mod changed during RUN -> ignored; result reflects the original operands, one finish only.
- rst_n low for one cycle at RUN cycle 5 -> out=0, finish=0, no finish afterwards. A new start then computes correctly (0x1234 mod 143 = 84).
- Random sweep against a reference model (in % mod): check result, exact latency, and finish pulse width, including back-to-back starts issued in the cycle right after finish.
